uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
- Byte FIFO plus frame pacer between the CPU's memory-mapped UART data-register store and the `uart` transmitter.
- Accepts bursts of CPU byte writes without stalling the pipeline.
- Feeds the transmitter one byte at a time as a 1-cycle `wr_en` pulse.
- The transmitter has no busy output and ignores `wr_en` while sending. This block therefore guarantees a fixed minimum spacing between pulses, covering the transmitter's worst-case frame time.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- SYSCLK_FREQ, `SYSCLK_FREQ, system clock frequency in Hz.
- BAUD_RATE, `BAUD_RATE, line rate in bit/s.
- BIT_CYCLES, ceil(SYSCLK_FREQ/BAUD_RATE), clocks per bit (local param).
- GAP_CYCLES, 12*BIT_CYCLES, minimum clocks between tx pulses: 11-bit frame plus 1 bit of baud-phase slack (local param).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  CPU store strobe to the UART data register
- wr_data  in  8  byte to send
- clr_ovf  in  1  clears the sticky overflow flag
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a write was dropped
- tx_wr_en  out  1  1-cycle strobe to the transmitter
- tx_wr_data  out  8  byte for the transmitter; valid while tx_wr_en=1

Behaviour:
- Reset (async assert, sync deassert use):
  - FIFO pointers and level = 0; empty=1, full=0, overflow=0.
  - tx_wr_en=0, tx_wr_data=8'h00, state=IDLE, gap counter=0.
- All outputs are registered; full, empty and level reflect the state after the previous edge.
- Push: wr_en=1 and level!=DEPTH → byte written at the write pointer, pointer wraps modulo DEPTH.
- Drop: wr_en=1 and level==DEPTH → byte discarded and overflow set.
  - A write is dropped even if a pop occurs in the same cycle; the decision uses the current level only.
- Overflow flag:
  - Cleared by clr_ovf=1.
  - If a drop and clr_ovf coincide, the set wins.
- Pacer FSM, two states:
  - IDLE with empty=0: pop the head, tx_wr_data<=head, tx_wr_en<=1 next cycle, gap counter<=GAP_CYCLES-1, go to GAP.
  - GAP: tx_wr_en<=0; decrement the counter each cycle; at counter==0 go to IDLE.
- Pulse spacing:
  - Back-to-back pulses are exactly GAP_CYCLES apart while the FIFO stays non-empty.
  - First-byte latency: wr_en in cycle N to an empty FIFO in IDLE → tx_wr_en=1 in cycle N+2. The push is visible at N+1 and the pop is registered at N+2.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Push into an empty FIFO is never popped in the same cycle.
- tx_wr_data holds its last value between pulses.
- Reset mid-gap or mid-burst:
  - All buffered bytes are lost.
  - No further tx_wr_en until a new write.
  - The transmitter is reset by the same rst_n.
- level width arithmetic: DEPTH must be representable, e.g. 5 bits for 16.

Decomposition:
- SYSCLK_FREQ and BAUD_RATE come from define.vh, where they are already defined.
- Add `UART_FRAME_BITS (11) and `UART_GAP_BITS (12) to define.vh.
- Sub-module `sync_fifo` (params WIDTH, DEPTH):
  - Ports: clk, rst_n, push, push_data, pop, pop_data, full, empty, level.
  - Implemented as a register array with unregistered head read.
- uart_tx_buffer contains sync_fifo, the pacer FSM, the gap counter and the overflow flag.

Test Plan (SYSCLK_FREQ=1000, BAUD_RATE=100 → BIT_CYCLES=10, GAP_CYCLES=120, DEPTH=4):
- Single byte: write 8'h41 at cycle 5 → tx_wr_en=1 only at cycle 7 with tx_wr_data=8'h41; empty=1 from cycle 8.
- Burst: write 8'h01..8'h03 in cycles 5-7 → pulses at 7, 127, 247 carrying 01, 02, 03; level peaks at 2 (one byte already popped).
- Overflow: write 8'h10..8'h15 in cycles 5-10 →
  - Sequence: 10 is popped at cycle 7; 11-14 fill to level 4; 15 is dropped and overflow=1.
  - Pulses carry 10, 11, 12, 13, 14 only.
  - Then clr_ovf=1 → overflow=0 next cycle.
- Concurrent push/pop: FIFO at level 3; write exactly at a pop cycle → level stays 3 and order is preserved.
- Reset mid-gap: rst_n low for 2 cycles at cycle 60 with 2 bytes queued → empty=1, level=0, tx_wr_en stays 0 for 500 cycles.
- Wrap: 10 single writes spaced 200 cycles → each pulse data matches input, confirming pointer wrap at DEPTH.

Source files
------------

// File: rtl/uart_tx_buffer_pkg.sv
// uart_tx_buffer_pkg: shared UART timing constants, pacer state codes and helpers
`ifndef SYSCLK_FREQ
`define SYSCLK_FREQ 50000000
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 115200
`endif
`ifndef UART_FRAME_BITS
`define UART_FRAME_BITS 11
`endif
`ifndef UART_GAP_BITS
`define UART_GAP_BITS 12
`endif

package uart_tx_buffer_pkg;
   localparam int DEF_SYSCLK_FREQ = `SYSCLK_FREQ;
   localparam int DEF_BAUD_RATE = `BAUD_RATE;
   localparam int GAP_BITS = `UART_GAP_BITS;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_GAP = 1'b1;
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction
endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// sync_fifo: register-array FIFO with combinational head read and registered flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   logic [LW-1:0] level_nxt;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign pop_data = mem[rd_ptr];
   // next occupancy; push and pop together leave it unchanged
   always_comb begin
      level_nxt = level + LW'(do_push) - LW'(do_pop);
   end
   // storage needs no reset: contents are only read behind a valid level
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         full <= 1'b0;
         empty <= 1'b1;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         level <= level_nxt;
         full <= level_nxt == LW'(DEPTH);
         empty <= level_nxt == '0;
      end
   end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus frame pacer feeding a busy-less UART transmitter
module uart_tx_buffer
   import uart_tx_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int SYSCLK_FREQ = DEF_SYSCLK_FREQ,
   parameter int BAUD_RATE = DEF_BAUD_RATE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   input  logic                   clr_ovf,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   tx_wr_en,
   output logic [7:0]             tx_wr_data
);
   localparam int BIT_CYCLES = ceil_div(SYSCLK_FREQ, BAUD_RATE);
   localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
   localparam int CW = $clog2(GAP_CYCLES);
   logic [0:0] state;
   logic [CW-1:0] gap_cnt;
   logic [7:0] head;
   logic pop, drop;
   // empty is registered, so a byte pushed this cycle is never popped this cycle
   assign pop = (state == ST_IDLE) && !empty;
   assign drop = wr_en && full;
   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(wr_en),
      .push_data(wr_data),
      .pop(pop),
      .pop_data(head),
      .full(full),
      .empty(empty),
      .level(level)
   );
   // pacer: one strobe per pop, then hold off until the counter reaches zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         gap_cnt <= '0;
         tx_wr_en <= 1'b0;
         tx_wr_data <= 8'h00;
      end else if (pop) begin
         state <= ST_GAP;
         gap_cnt <= CW'(GAP_CYCLES - 1);
         tx_wr_en <= 1'b1;
         tx_wr_data <= head;
      end else begin
         tx_wr_en <= 1'b0;
         gap_cnt <= (state == ST_GAP) ? gap_cnt - CW'(1) : gap_cnt;
         state <= (state == ST_GAP && gap_cnt == CW'(1)) ? ST_IDLE : state;
      end
   end
   // sticky overflow; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow <= 1'b0;
      else overflow <= drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow);
   end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: vector table, plan sequences and random traffic against a queue model
module tb_uart_tx_buffer;
   localparam int DEPTH = 4;
   localparam int SYSCLK = 1000;
   localparam int BAUD = 100;
   localparam int G = 120;
   localparam int LW = 3;

   typedef struct {
      bit we;
      logic [7:0] d;
      bit clr;
      int lvl;
      bit tx;
      logic [7:0] data;
      bit ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wr_en = 1'b0;
   logic clr_ovf = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic full, empty, overflow, tx_wr_en;
   logic [LW-1:0] level;
   logic [7:0] tx_wr_data;

   uart_tx_buffer #(.DEPTH(DEPTH), .SYSCLK_FREQ(SYSCLK), .BAUD_RATE(BAUD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .clr_ovf(clr_ovf),
      .full(full),
      .empty(empty),
      .level(level),
      .overflow(overflow),
      .tx_wr_en(tx_wr_en),
      .tx_wr_data(tx_wr_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int max_level = 0;
   logic [7:0] q[$];
   int last_pulse;
   bit m_ovf, m_tx;
   logic [7:0] m_data;
   logic [7:0] pulses[$];
   int pulse_cyc[$];
   vec_t tbl[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // reference: a byte queue plus "no two pulses closer than G cycles"
   task automatic model_reset();
      q.delete();
      last_pulse = -100000;
      m_ovf = 1'b0;
      m_tx = 1'b0;
      m_data = 8'h00;
   endtask

   task automatic model_edge(input bit we, input logic [7:0] d, input bit clr);
      int pre;
      pre = q.size();
      m_tx = (pre > 0) && (cyc + 1 - last_pulse >= G);
      if (m_tx) begin
         m_data = q.pop_front();
         last_pulse = cyc + 1;
      end
      if (we && pre == DEPTH) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (we && pre < DEPTH) q.push_back(d);
   endtask

   task automatic compare_model();
      logic [14:0] act, exp;
      act = {level, empty, full, overflow, tx_wr_en, tx_wr_data};
      exp = {LW'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf, m_tx, m_data};
      check("model", 32'(act), 32'(exp));
   endtask

   task automatic step(input bit we, input logic [7:0] d, input bit clr);
      wr_en = we;
      wr_data = d;
      clr_ovf = clr;
      @(posedge clk);
      model_edge(we, d, clr);
      cyc++;
      #1;
      wr_en = 1'b0;
      clr_ovf = 1'b0;
      compare_model();
      if (tx_wr_en === 1'b1) begin
         pulses.push_back(tx_wr_data);
         pulse_cyc.push_back(cyc);
      end
      if (int'(level) > max_level) max_level = int'(level);
   endtask

   task automatic idle_until(input int c);
      while (cyc < c) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      model_reset();
      cyc = 0;
      compare_model();
      rst_n = 1'b1;
      pulses.delete();
      pulse_cyc.delete();
      max_level = 0;
   endtask

   function automatic vec_t v(input bit we, input logic [7:0] d, input bit clr,
                              input int lvl, input bit tx, input logic [7:0] data, input bit ovf);
      vec_t r;
      r.we = we; r.d = d; r.clr = clr; r.lvl = lvl; r.tx = tx; r.data = data; r.ovf = ovf;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      // each row: inputs for cycle i, outputs expected in cycle i+1
      for (int i = 0; i < 5; i++) tbl[i] = v(0, 8'h00, 0, 0, 0, 8'h00, 0);
      tbl[5]  = v(1, 8'h41, 0, 1, 0, 8'h00, 0);
      tbl[6]  = v(0, 8'h00, 0, 0, 1, 8'h41, 0);
      tbl[7]  = v(0, 8'h00, 0, 0, 0, 8'h41, 0);
      tbl[8]  = v(1, 8'h01, 0, 1, 0, 8'h41, 0);
      tbl[9]  = v(1, 8'h02, 0, 2, 0, 8'h41, 0);
      tbl[10] = v(1, 8'h03, 0, 3, 0, 8'h41, 0);
      tbl[11] = v(1, 8'h04, 0, 4, 0, 8'h41, 0);
      tbl[12] = v(1, 8'h05, 0, 4, 0, 8'h41, 1);
      tbl[13] = v(0, 8'h00, 1, 4, 0, 8'h41, 0);
      tbl[14] = v(1, 8'h06, 1, 4, 0, 8'h41, 1);
      tbl[15] = v(0, 8'h00, 1, 4, 0, 8'h41, 0);

      do_reset(3);
      check("reset_empty", 32'(empty), 1);
      check("reset_full", 32'(full), 0);
      check("reset_level", 32'(level), 0);
      check("reset_txdata", 32'(tx_wr_data), 0);
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].we, tbl[i].d, tbl[i].clr);
         check("vec_level", 32'(level), 32'(tbl[i].lvl));
         check("vec_full", 32'(full), 32'(tbl[i].lvl == DEPTH));
         check("vec_empty", 32'(empty), 32'(tbl[i].lvl == 0));
         check("vec_tx", 32'(tx_wr_en), 32'(tbl[i].tx));
         check("vec_data", 32'(tx_wr_data), 32'(tbl[i].data));
         check("vec_ovf", 32'(overflow), 32'(tbl[i].ovf));
      end

      // burst of three: pulses exactly G apart, one byte already gone at peak
      do_reset(2);
      idle_until(5);
      for (int i = 0; i < 3; i++) step(1'b1, 8'(i + 1), 1'b0);
      while (pulses.size() < 3 && cyc < 400) step(1'b0, 8'h00, 1'b0);
      check("burst_count", 32'(pulses.size()), 3);
      for (int i = 0; i < 3 && i < pulses.size(); i++) begin
         check("burst_cycle", 32'(pulse_cyc[i]), 32'(7 + i * G));
         check("burst_data", 32'(pulses[i]), 32'(i + 1));
      end
      check("burst_peak", 32'(max_level), 2);

      // overflow: sixth byte dropped, sticky until cleared
      do_reset(2);
      idle_until(5);
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      check("ovf_set", 32'(overflow), 1);
      check("ovf_level", 32'(level), 4);
      idle_until(700);
      check("ovf_count", 32'(pulses.size()), 5);
      for (int i = 0; i < 5 && i < pulses.size(); i++)
         check("ovf_data", 32'(pulses[i]), 32'(8'h10 + i));
      check("ovf_held", 32'(overflow), 1);
      step(1'b0, 8'h00, 1'b1);
      check("ovf_clear", 32'(overflow), 0);

      // write landing exactly on a pop edge at level 3
      do_reset(2);
      idle_until(5);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
      check("cc_level_before", 32'(level), 3);
      idle_until(126);
      step(1'b1, 8'h24, 1'b0);
      check("cc_level", 32'(level), 3);
      check("cc_pulse", 32'(tx_wr_en), 1);
      check("cc_head", 32'(tx_wr_data), 32'h21);
      idle_until(700);
      check("cc_count", 32'(pulses.size()), 5);
      for (int i = 0; i < 5 && i < pulses.size(); i++)
         check("cc_order", 32'(pulses[i]), 32'(8'h20 + i));

      // reset in the middle of a gap with bytes queued
      do_reset(2);
      idle_until(5);
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      idle_until(60);
      check("rst_queued", 32'(level), 2);
      do_reset(2);
      check("rst_empty", 32'(empty), 1);
      check("rst_level", 32'(level), 0);
      idle_until(500);
      check("rst_silent", 32'(pulses.size()), 0);

      // ten spaced writes walk the pointers around the ring twice
      do_reset(2);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 8'(8'h50 + k * 7), 1'b0);
         repeat (199) step(1'b0, 8'h00, 1'b0);
      end
      check("wrap_count", 32'(pulses.size()), 10);
      for (int k = 0; k < 10 && k < pulses.size(); k++)
         check("wrap_data", 32'(pulses[k]), 32'(8'h50 + k * 7));

      // random traffic with varying write density, clears and rare resets
      do_reset(2);
      for (int i = 0; i < 4000; i++) begin
         int rate;
         rate = (i / 500) % 2 == 0 ? 2 : 30;
         if ($urandom_range(0, 1999) == 0) do_reset(2);
         step($urandom_range(0, 99) < rate, 8'($urandom), $urandom_range(0, 49) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
